// File: rtl/seq_normalizer.sv
// seq_normalizer: multi-cycle left-normalizer for 32-bit operands.
// An accepted operand is shifted left one bit per cycle until its top bit
// (unsigned) or its top two bits differ (signed), reporting the shift count.
// A zero operand completes immediately with out_zero=1 and out_shamt=32.
// Optional feature macro: NORM_SIGNED_EN enables the signed mode selected by
// in_signed; without it in_signed is ignored and every operand is unsigned.
module seq_normalizer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [5:0]  out_shamt,
    output logic        out_zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] work;
    logic [4:0]  count;
    logic        mode;
    logic        eff_signed;
    logic        normalized;

`ifdef NORM_SIGNED_EN
    assign eff_signed = in_signed;
`else
    // Port kept for drop-in compatibility; its value is deliberately unused.
    logic unused_in_signed;
    assign unused_in_signed = in_signed;
    assign eff_signed       = 1'b0;
`endif

    // Normalization test on the working register for the captured mode
    always_comb begin
        normalized = 1'b0;
        if (mode)
            normalized = work[31] ^ work[30];
        else
            normalized = work[31];
    end

    // Control FSM with registered handshakes and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            count     <= '0;
            mode      <= 1'b0;
            out_data  <= '0;
            out_shamt <= '0;
            out_zero  <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= in_data;
                        mode     <= eff_signed;
                        count    <= '0;
                        in_ready <= 1'b0;
                        if (in_data == '0) begin
                            state     <= DONE;
                            out_data  <= '0;
                            out_shamt <= 6'd32;
                            out_zero  <= 1'b1;
                            out_valid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (normalized || (count == 5'd31)) begin
                        state     <= DONE;
                        out_data  <= work;
                        out_shamt <= {1'b0, count};
                        out_zero  <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        work  <= {work[30:0], 1'b0};
                        count <= count + 5'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_normalizer.sv
// Self-checking bench for seq_normalizer (scoreboard of expected results).
// Build with or without +define+NORM_SIGNED_EN; expectations follow the macro.
module tb_seq_normalizer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_shamt;
    logic        out_zero;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  shamt;
        logic        zero;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    seq_normalizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shamt (out_shamt),
        .out_zero  (out_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: count redundant leading bits directly from the operand
    function automatic exp_t model(input logic [31:0] x, input logic s);
        exp_t e;
        int   n;
        logic se;
`ifdef NORM_SIGNED_EN
        se = s;
`else
        se = 1'b0;
`endif
        n = 0;
        if (x == 32'd0) begin
            e.data = 32'd0; e.shamt = 6'd32; e.zero = 1'b1; e.lat = 1;
        end else begin
            if (se) begin
                while (n < 31 && x[30-n] == x[31]) n++;
            end else begin
                while (n < 31 && !x[31-n]) n++;
            end
            e.data = x << n; e.shamt = 6'(n); e.zero = 1'b0; e.lat = 2 + n;
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] d, input logic [5:0] sh, input logic z);
        exp_t e;
        e.data = d; e.shamt = sh; e.zero = z;
        e.lat  = z ? 1 : 2 + int'(sh);
        return e;
    endfunction

    // Offer one operand, wait (bounded) for out_valid; returns at a negedge
    task automatic do_op(input logic [31:0] d, input logic s, output int lat, output bit tmo);
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = s;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        tmo = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                tmo = 1'b0;
                break;
            end
            lat++;
            @(posedge clk);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        total++; if (out_data !== 32'd0 || out_shamt !== 6'd0 || out_zero !== 1'b0)
            $display("FAIL reset_outputs got %h/%0d/%b want 0/0/0", out_data, out_shamt, out_zero); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [31:0] d_in [7];
        logic        s_in [7];
        exp_t        e;
        exp_t        ex [7];
        int          lat;
        bit          tmo;
        d_in[0] = 32'h0000_0001; s_in[0] = 1'b0; ex[0] = mk(32'h8000_0000, 6'd31, 1'b0);
        d_in[1] = 32'h8000_0000; s_in[1] = 1'b0; ex[1] = mk(32'h8000_0000, 6'd0,  1'b0);
        d_in[2] = 32'h0000_0000; s_in[2] = 1'b0; ex[2] = mk(32'h0000_0000, 6'd32, 1'b1);
        d_in[3] = 32'h0000_0000; s_in[3] = 1'b1; ex[3] = mk(32'h0000_0000, 6'd32, 1'b1);
`ifdef NORM_SIGNED_EN
        d_in[4] = 32'hFFFF_0000; s_in[4] = 1'b1; ex[4] = mk(32'h8000_0000, 6'd15, 1'b0);
        d_in[5] = 32'h0000_0001; s_in[5] = 1'b1; ex[5] = mk(32'h4000_0000, 6'd30, 1'b0);
        d_in[6] = 32'hFFFF_FFFF; s_in[6] = 1'b1; ex[6] = mk(32'h8000_0000, 6'd31, 1'b0);
`else
        d_in[4] = 32'hFFFF_0000; s_in[4] = 1'b1; ex[4] = mk(32'hFFFF_0000, 6'd0,  1'b0);
        d_in[5] = 32'h0000_0001; s_in[5] = 1'b1; ex[5] = mk(32'h8000_0000, 6'd31, 1'b0);
        d_in[6] = 32'hFFFF_FFFF; s_in[6] = 1'b1; ex[6] = mk(32'hFFFF_FFFF, 6'd0,  1'b0);
`endif
        for (int i = 0; i < 7; i++) begin
            sb.push_back(ex[i]);
            do_op(d_in[i], s_in[i], lat, tmo);
            e = sb.pop_front();
            total++; if (tmo) $display("FAIL dir%0d_timeout no out_valid within bound", i); else passed++;
            total++; if (out_data !== e.data) $display("FAIL dir%0d_data got %h want %h", i, out_data, e.data); else passed++;
            total++; if (out_shamt !== e.shamt) $display("FAIL dir%0d_shamt got %0d want %0d", i, out_shamt, e.shamt); else passed++;
            total++; if (out_zero !== e.zero) $display("FAIL dir%0d_zero got %b want %b", i, out_zero, e.zero); else passed++;
            total++; if (lat != e.lat) $display("FAIL dir%0d_latency got %0d want %0d", i, lat, e.lat); else passed++;
            consume();
            @(negedge clk);
            total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
                $display("FAIL dir%0d_release got ready=%b valid=%b want 1/0", i, in_ready, out_valid); else passed++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        exp_t        e;
        logic [31:0] x;
        logic        s;
        int          lat;
        bit          tmo;
        for (int i = 0; i < 10; i++) begin
            x = $urandom() >> $urandom_range(0, 31);
            s = 1'($urandom_range(0, 1));
            sb.push_back(model(x, s));
            do_op(x, s, lat, tmo);
            e = sb.pop_front();
            total++; if (tmo || out_data !== e.data || out_shamt !== e.shamt || out_zero !== e.zero || lat != e.lat)
                $display("FAIL rand%0d op=%h s=%b got %h/%0d/%b lat %0d want %h/%0d/%b lat %0d",
                         i, x, s, out_data, out_shamt, out_zero, lat, e.data, e.shamt, e.zero, e.lat);
            else passed++;
            consume();
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        bit   tmo;
        sb.push_back(mk(32'hC000_0000, 6'd2, 1'b0));
        do_op(32'h3000_0000, 1'b0, lat, tmo);
        e = sb.pop_front();
        total++; if (tmo || out_data !== e.data || out_shamt !== e.shamt || out_zero !== e.zero)
            $display("FAIL bp_result got %h/%0d/%b want %h/%0d/%b", out_data, out_shamt, out_zero, e.data, e.shamt, e.zero);
        else passed++;
        in_valid = 1'b1;
        in_data  = 32'h0000_0000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== e.data || out_shamt !== e.shamt || out_zero !== e.zero)
                $display("FAIL bp_hold%0d got v=%b r=%b %h/%0d/%b want v=1 r=0 %h/%0d/%b",
                         c, out_valid, in_ready, out_data, out_shamt, out_zero, e.data, e.shamt, e.zero);
            else passed++;
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_release got ready=%b valid=%b want 1/0", in_ready, out_valid); else passed++;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_no_capture got ready=%b valid=%b want 1/0", in_ready, out_valid); else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_shift();
        exp_t e;
        int   lat;
        bit   tmo;
        sb.push_back(mk(32'h8000_0000, 6'd15, 1'b0));
        in_valid = 1'b1; in_data = 32'h0001_0000; in_signed = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        void'(sb.pop_front());
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rst_immediate got valid=%b ready=%b want 0/1", out_valid, in_ready); else passed++;
        total++; if (out_data !== 32'd0 || out_shamt !== 6'd0 || out_zero !== 1'b0)
            $display("FAIL rst_clear got %h/%0d/%b want 0/0/0", out_data, out_shamt, out_zero); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(mk(32'h8000_0000, 6'd1, 1'b0));
        do_op(32'h4000_0000, 1'b0, lat, tmo);
        e = sb.pop_front();
        total++; if (tmo || out_data !== e.data || out_shamt !== e.shamt || out_zero !== e.zero || lat != e.lat)
            $display("FAIL rst_after got %h/%0d/%b lat %0d want %h/%0d/%b lat %0d",
                     out_data, out_shamt, out_zero, lat, e.data, e.shamt, e.zero, e.lat);
        else passed++;
        consume();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        #11;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_normalizer.md
SEQ_NORMALIZER -- requirements
Module: seq_normalizer

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 The ports SHALL be as follows, clock and reset first:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  block can accept an operand.
- in_data  input  32  operand.
- in_signed  input  1  0 = unsigned normalize, 1 = signed normalize.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_data  output  32  normalized value.
- out_shamt  output  6  left-shift count, 0..32.
- out_zero  output  1  operand was zero.

Function
REQ-003 The block SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-004 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-005 In IDLE, in_valid&&in_ready SHALL capture in_data and the effective mode into an internal working register and clear the count to 0.
- If in_data==0, the next state SHALL be DONE, with out_zero=1, out_shamt=32, out_data=0.
- Otherwise the next state SHALL be SHIFT.
REQ-006 The normalized condition SHALL be:
- unsigned: bit31==1;
- signed: bit31!=bit30.
REQ-007 Each SHIFT cycle SHALL, in priority order:
- if normalized or count==31, go to DONE;
- otherwise shift the working register left by 1, zero-fill bit0, and increment count.
REQ-008 Latency SHALL be measured from the acceptance cycle T:
- nonzero operand: out_valid asserts in cycle T+2+out_shamt;
- zero operand: out_valid asserts in cycle T+1.
REQ-009 In DONE, out_data, out_shamt and out_zero SHALL stay stable until out_valid&&out_ready.
- The handshake SHALL return the FSM to IDLE next cycle.
- No new operand SHALL be accepted in the same cycle.
REQ-010 The outputs SHALL hold their last values in IDLE and SHIFT.
- Consumers SHALL qualify them only with out_valid.
REQ-011 Signed all-ones (0xFFFFFFFF) SHALL terminate at count 31 with out_data=0x80000000, out_shamt=31.
REQ-012 in_valid while in SHIFT or DONE SHALL be ignored, and no state change SHALL result.
REQ-013 out_ready while not in DONE SHALL have no effect.
REQ-014 out_shamt SHALL never exceed 31 for a nonzero operand.
REQ-015 out_zero SHALL be 0 for every nonzero operand.

Reset
REQ-016 Asserting rst_n low SHALL immediately force IDLE, independent of clk.
- It SHALL clear: working register, count, out_data=0, out_shamt=0, out_zero=0, out_valid=0.
- It SHALL set in_ready=1.
REQ-017 Reset asserted mid-SHIFT or in DONE SHALL discard the operation with no result emitted.
- After release, the first rising edge SHALL find the block in IDLE and able to accept.

Configuration
REQ-018 Macro NORM_SIGNED_EN SHALL control signed mode.
- Defined: in_signed selects the signed condition per REQ-006.
- Undefined: in_signed is ignored and treated as 0; the port remains present; all operations use the unsigned condition.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Unsigned 0x00000001 -> out_data=0x80000000, out_shamt=31, out_zero=0, out_valid at T+33.
- Unsigned 0x80000000 -> out_data=0x80000000, out_shamt=0, out_valid at T+2.
- Operand 0x00000000 (either mode) -> out_zero=1, out_shamt=32, out_data=0, out_valid at T+1.
- With NORM_SIGNED_EN: signed 0xFFFF0000 -> out_data=0x80000000, out_shamt=15; signed 0x00000001 -> 0x40000000, shamt 30; signed 0xFFFFFFFF -> 0x80000000, shamt 31. Without the macro: 0xFFFF0000 with in_signed=1 -> out_shamt=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored. Then raise out_ready -> in_ready=1 next cycle.
- Drop rst_n mid-SHIFT (operand 0x00010000, 4 cycles in) -> out_valid=0 and in_ready=1 immediately. After release, a new operand 0x40000000 -> out_shamt=1.
